// File: rtl/nos_bar_draw.sv
// ============================================================================
// Module  : nos_bar_draw
// Brief   : Nitrous-bar HUD driver. Tracks the nitrous level (boost drain and
//           passive recharge), and renders the bar through rom_nos_bar with a
//           fixed 2-cycle pixel latency. Optional low-level blink is compiled in
//           with the NOS_BAR_BLINK_EN macro.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nos_bar_draw #(
    parameter int BAR_W        = 60,
    parameter int BAR_H        = 10,
    parameter int BAR_X        = 560,
    parameter int BAR_Y        = 16,
    parameter int DRAIN_FRAMES = 2,
    parameter int RECHG_FRAMES = 30,
    parameter int LOW_THRESH   = 12
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        boost_req,
    input  logic        nos_pickup,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [10:0] rom_addr,
    input  logic [23:0] rom_data,
    output logic        boost_active,
    output logic [5:0]  nos_level,
    output logic        nos_low,
    output logic        pixel_on,
    output logic [23:0] nos_rgb
);

    localparam int c_cnt_max = (RECHG_FRAMES > DRAIN_FRAMES) ? RECHG_FRAMES : DRAIN_FRAMES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [5:0]           c_full     = 6'(BAR_W);
    localparam logic [5:0]           c_low      = 6'(LOW_THRESH);
    localparam logic [c_cnt_w-1:0]   c_drain_end = c_cnt_w'(DRAIN_FRAMES - 1);
    localparam logic [c_cnt_w-1:0]   c_rechg_end = c_cnt_w'(RECHG_FRAMES - 1);
    localparam logic signed [10:0]   c_bar_x    = 11'(BAR_X);
    localparam logic signed [10:0]   c_bar_y    = 11'(BAR_Y);
    localparam logic signed [10:0]   c_bar_w_s  = 11'(BAR_W);
    localparam logic signed [10:0]   c_bar_h_s  = 11'(BAR_H);
    localparam logic [10:0]          c_bar_w_u  = 11'(BAR_W);
    localparam logic [10:0]          c_img      = 11'(BAR_W * BAR_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BOOST = 2'd1,
        S_EMPTY = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [5:0]           r_level, w_level_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic                 r_boost_active;

    logic [10:0]          r_rom_addr;
    logic                 r_in_bar_d1;
    logic                 r_pixel_on;
    logic                 w_visible;

    // ------------------------------------------------------------------
    // Level state machine
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state        <= S_IDLE;
            r_level        <= c_full;
            r_cnt          <= '0;
            r_boost_active <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_level        <= w_level_nxt;
            r_cnt          <= w_cnt_nxt;
            r_boost_active <= (r_state == S_BOOST);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (boost_req && (r_level != 6'd0)) begin
                    w_state_nxt = S_BOOST;
                    w_cnt_nxt   = '0;
                end else if (frame_tick) begin
                    if (r_cnt == c_rechg_end) begin
                        w_cnt_nxt = '0;
                        if (r_level < c_full)
                            w_level_nxt = r_level + 6'd1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_BOOST: begin
                if (!boost_req) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_level == 6'd0) begin
                    w_state_nxt = S_EMPTY;
                    w_cnt_nxt   = '0;
                end else if (frame_tick) begin
                    if (r_cnt == c_drain_end) begin
                        w_cnt_nxt   = '0;
                        w_level_nxt = r_level - 6'd1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_EMPTY: begin
                w_cnt_nxt = '0;
                if (!boost_req)
                    w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // A pickup overrides any drain/recharge and only re-arms boost from EMPTY
        if (nos_pickup) begin
            w_level_nxt = c_full;
            w_cnt_nxt   = '0;
            w_state_nxt = (r_state == S_EMPTY && boost_req) ? S_BOOST : r_state;
        end
    end

    assign boost_active = r_boost_active;
    assign nos_level    = r_level;
    assign nos_low      = (r_level <= c_low);

    // ------------------------------------------------------------------
    // Render pipeline: S0 decode, S1 address register, S2 ROM + pixel flag
    // ------------------------------------------------------------------
    logic signed [10:0] w_rx, w_ry;
    logic               w_in_bar, w_loaded;
    logic [10:0]        w_addr;

    assign w_rx     = $signed({1'b0, DrawX}) - c_bar_x;
    assign w_ry     = $signed({1'b0, DrawY}) - c_bar_y;
    assign w_in_bar = (w_rx >= 11'sd0) && (w_rx < c_bar_w_s) &&
                      (w_ry >= 11'sd0) && (w_ry < c_bar_h_s);
    assign w_loaded = (w_rx < $signed({5'b0, r_level}));
    assign w_addr   = $unsigned(w_ry) * c_bar_w_u + $unsigned(w_rx) +
                      (w_loaded ? c_img : 11'd0);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_rom_addr  <= '0;
            r_in_bar_d1 <= 1'b0;
            r_pixel_on  <= 1'b0;
        end else begin
            r_rom_addr  <= w_in_bar ? w_addr : 11'd0;
            r_in_bar_d1 <= w_in_bar;
            r_pixel_on  <= r_in_bar_d1;
        end
    end

`ifdef NOS_BAR_BLINK_EN
    logic       r_blink;
    logic [3:0] r_blink_cnt;

    // Blink phase restarts from visible each time the level leaves the low band
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
        end else if (!nos_low) begin
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
        end else if (frame_tick) begin
            r_blink_cnt <= r_blink_cnt + 4'd1;
            if (r_blink_cnt == 4'd15)
                r_blink <= ~r_blink;
        end
    end

    assign w_visible = r_blink;
`else
    assign w_visible = 1'b1;
`endif

    assign rom_addr = r_rom_addr;
    assign pixel_on = r_pixel_on & w_visible;
    assign nos_rgb  = pixel_on ? rom_data : 24'd0;

endmodule

`default_nettype wire

// File: tb/tb_nos_bar_draw.sv
// ============================================================================
// Module  : tb_nos_bar_draw
// Brief   : Directed and randomized bench for nos_bar_draw against a
//           behavioural level/render model and a registered ROM model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nos_bar_draw;

    localparam int BAR_W = 60, BAR_H = 10, BAR_X = 560, BAR_Y = 16;
    localparam int DRAIN_FRAMES = 2, RECHG_FRAMES = 30, LOW_THRESH = 12;
    localparam int M_IDLE = 0, M_BOOST = 1, M_EMPTY = 2;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_tick = 1'b0, boost_req = 1'b0, nos_pickup = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic [10:0] rom_addr;
    logic [23:0] rom_data = '0;
    logic        boost_active, nos_low, pixel_on;
    logic [5:0]  nos_level;
    logic [23:0] nos_rgb;

    int n_chk = 0, n_pass = 0;

    // model state
    int m_mode, m_level, m_ticks, m_addr, m_inbar_d1, m_pix, m_rgb_addr, m_ba;
    int m_blink, m_lowticks;

    always #5 Clk = ~Clk;

    nos_bar_draw dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .boost_req(boost_req), .nos_pickup(nos_pickup),
        .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr), .rom_data(rom_data),
        .boost_active(boost_active), .nos_level(nos_level), .nos_low(nos_low),
        .pixel_on(pixel_on), .nos_rgb(nos_rgb)
    );

    function automatic logic [23:0] rom_word(input logic [10:0] a);
        return {1'b1, a, 1'b0, a ^ 11'h2A5};
    endfunction

    always @(posedge Clk) rom_data <= rom_word(rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_edge();
        int pre_level, pre_mode, rx, ry;
        bit inb;
        pre_level = m_level;
        pre_mode  = m_mode;
        if (!Reset_n) begin
            m_mode = M_IDLE; m_level = BAR_W; m_ticks = 0; m_addr = 0;
            m_inbar_d1 = 0; m_pix = 0; m_rgb_addr = 0; m_ba = 0;
            m_blink = 1; m_lowticks = 0;
            return;
        end
        rx  = int'(DrawX) - BAR_X;
        ry  = int'(DrawY) - BAR_Y;
        inb = (rx >= 0) && (rx < BAR_W) && (ry >= 0) && (ry < BAR_H);
        m_rgb_addr = m_addr;
        m_pix      = m_inbar_d1;
        m_inbar_d1 = inb;
        m_addr     = inb ? (ry * BAR_W + rx + ((rx < pre_level) ? BAR_W * BAR_H : 0)) : 0;
        m_ba       = (pre_mode == M_BOOST);
`ifdef NOS_BAR_BLINK_EN
        if (pre_level > LOW_THRESH) begin
            m_blink = 1; m_lowticks = 0;
        end else if (frame_tick) begin
            m_lowticks++;
            if (m_lowticks % 16 == 0) m_blink = !m_blink;
        end
`endif
        if (nos_pickup) begin
            m_level = BAR_W; m_ticks = 0;
            if (pre_mode == M_EMPTY && boost_req) m_mode = M_BOOST;
        end else begin
            case (pre_mode)
                M_IDLE:
                    if (boost_req && pre_level > 0) begin
                        m_mode = M_BOOST; m_ticks = 0;
                    end else if (frame_tick) begin
                        m_ticks++;
                        if (m_ticks == RECHG_FRAMES) begin
                            m_ticks = 0;
                            m_level = (m_level < BAR_W) ? m_level + 1 : BAR_W;
                        end
                    end
                M_BOOST:
                    if (!boost_req) begin
                        m_mode = M_IDLE; m_ticks = 0;
                    end else if (pre_level == 0) begin
                        m_mode = M_EMPTY; m_ticks = 0;
                    end else if (frame_tick) begin
                        m_ticks++;
                        if (m_ticks == DRAIN_FRAMES) begin
                            m_ticks = 0; m_level--;
                        end
                    end
                default: begin
                    m_ticks = 0;
                    if (!boost_req) m_mode = M_IDLE;
                end
            endcase
        end
    endtask

    task automatic check_all();
        int exp_pix;
        exp_pix = (m_pix != 0 && m_blink != 0) ? 1 : 0;
        check("rom_addr", rom_addr, m_addr);
        check("pixel_on", pixel_on, exp_pix);
        check("nos_rgb", nos_rgb, (exp_pix != 0) ? rom_word(11'(m_rgb_addr)) : 24'd0);
        check("nos_level", nos_level, m_level);
        check("nos_low", nos_low, (m_level <= LOW_THRESH) ? 1 : 0);
        check("boost_active", boost_active, m_ba);
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic tick();
        frame_tick = 1'b1; step();
        frame_tick = 1'b0; step();
    endtask

    task automatic scan(input int x, input int y);
        DrawX = 10'(x); DrawY = 10'(y);
        step();
        DrawX = '0; DrawY = '0;
    endtask

    int ox[4] = '{BAR_X - 1, BAR_X + BAR_W, BAR_X, 0};
    int oy[4] = '{BAR_Y, BAR_Y, BAR_Y + BAR_H, 0};

    initial begin
        m_blink = 1; m_lowticks = 0;
        // reset
        Reset_n = 1'b0;
        repeat (3) step();
        check("rst_level", nos_level, 60);
        check("rst_addr", rom_addr, 0);
        check("rst_pix", pixel_on, 0);
        check("rst_boost", boost_active, 0);
        Reset_n = 1'b1;
        step();

        // top-left pixel of a full bar
        scan(BAR_X, BAR_Y);
        check("tl_addr", rom_addr, 600);
        step();
        check("tl_pix", pixel_on, 1);
        check("tl_rgb", nos_rgb, rom_word(11'd600));

        // bottom-right pixel of a full bar: maximum address
        scan(BAR_X + 59, BAR_Y + 9);
        check("br_addr", rom_addr, 1199);

        // boost for 10 frames
        boost_req = 1'b1;
        step(); step();
        repeat (10) tick();
        check("boost_level", nos_level, 55);
        check("boost_active", boost_active, 1);
        scan(BAR_X + 57, BAR_Y + 1);
        check("boost_addr", rom_addr, 117);

        // drain to empty and keep holding
        repeat (110) tick();
        repeat (3) step();
        check("empty_level", nos_level, 0);
        check("empty_boost", boost_active, 0);
        scan(BAR_X + 5, BAR_Y + 2);
        check("empty_addr", rom_addr, 125);
        repeat (40) tick();
        check("empty_hold", nos_level, 0);
        check("empty_hold_ba", boost_active, 0);

        // release and recharge
        boost_req = 1'b0;
        step(); step();
        repeat (29) tick();
        check("rechg_29", nos_level, 0);
        tick();
        check("rechg_30", nos_level, 1);

        // pickup, then boost down to 3 and pickup on a drain tick
        nos_pickup = 1'b1; step(); nos_pickup = 1'b0;
        check("pickup_level", nos_level, 60);
        boost_req = 1'b1;
        step(); step();
        repeat (114) tick();
        check("lvl3", nos_level, 3);
        check("lvl3_low", nos_low, 1);
        tick();
        frame_tick = 1'b1; nos_pickup = 1'b1;
        step();
        frame_tick = 1'b0; nos_pickup = 1'b0;
        check("pick_drain_level", nos_level, 60);
        step(); step();
        check("pick_drain_boost", boost_active, 1);
        boost_req = 1'b0;
        step();

        // scans just outside the bar
        for (int i = 0; i < 4; i++) begin
            scan(ox[i], oy[i]);
            check("out_addr", rom_addr, 0);
            step();
            check("out_pix", pixel_on, 0);
            check("out_rgb", nos_rgb, 0);
        end

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) boost_req = ~boost_req;
            frame_tick = ($urandom_range(0, 2) == 0);
            nos_pickup = ($urandom_range(0, 299) == 0);
            Reset_n    = ($urandom_range(0, 1999) != 0);
            if ($urandom_range(0, 9) == 0) begin
                DrawX = 10'($urandom_range(0, 1023));
                DrawY = 10'($urandom_range(0, 1023));
            end else begin
                DrawX = 10'($urandom_range(BAR_X - 4, BAR_X + BAR_W + 4));
                DrawY = 10'($urandom_range(BAR_Y - 3, BAR_Y + BAR_H + 3));
            end
            step();
        end
        Reset_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
